// File: rtl/i2s_sample_fifo.sv
// Sample FIFO between the AVR register port and the I2S transmitter.
// Byte-pair pushes from the AVR; one pop per rising edge of lrck; refill request on low water.
module i2s_sample_fifo #(
   parameter int         AW       = 4,
   parameter logic [1:0] ADR_LO   = 2'b00,
   parameter logic [1:0] ADR_HI   = 2'b01,
   parameter logic [1:0] ADR_CTRL = 2'b10,
   parameter logic [1:0] ADR_LVL  = 2'b11
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  din,
   input  logic        wd,
   input  logic [1:0]  A,
   output logic [7:0]  dout,
   input  logic        lrck,
   output logic [15:0] sample_out,
   output logic        req
);

   localparam int          DEPTH    = 2 ** AW;
   localparam logic [AW:0] LVL_ZERO = {(AW + 1){1'b0}};
   localparam logic [AW:0] LVL_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] LVL_FULL = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] THR_RST  = (AW + 1)'(8);
   localparam logic [AW-1:0] PTR_ONE = {{(AW - 1){1'b0}}, 1'b1};

   logic [15:0]   mem_r [DEPTH];
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [AW:0]   level_r;
   logic [AW:0]   level_s;
   logic [AW:0]   threshold_r;
   logic [7:0]    lo_hold_r;
   logic          enable_r;
   logic          ovf_r;
   logic          unf_r;
   logic          lrck_d_r;

   logic          rise_s;
   logic          empty_s;
   logic          full_s;
   logic          wr_lo_s;
   logic          wr_hi_s;
   logic          wr_ctrl_s;
   logic          wr_lvl_s;
   logic          flush_s;
   logic          clr_s;
   logic          push_s;
   logic          pop_s;
   logic          ovf_set_s;
   logic          unf_set_s;

   // Strobe decode, push/pop qualification and next fill level
   always_comb begin
      rise_s    = lrck & ~lrck_d_r;
      empty_s   = (level_r == LVL_ZERO);
      full_s    = (level_r == LVL_FULL);
      wr_lo_s   = wd & (A == ADR_LO);
      wr_hi_s   = wd & (A == ADR_HI);
      wr_ctrl_s = wd & (A == ADR_CTRL);
      wr_lvl_s  = wd & (A == ADR_LVL);
      flush_s   = wr_ctrl_s & din[2];
      clr_s     = wr_ctrl_s & din[1];
      // full is judged on the starting level, so a same-cycle pop never makes room
      ovf_set_s = wr_hi_s & full_s;
      unf_set_s = rise_s & enable_r & empty_s;
      push_s    = wr_hi_s & ~full_s & ~flush_s;
      pop_s     = rise_s & enable_r & ~empty_s & ~flush_s;
      level_s   = level_r;
      if (flush_s) begin
         level_s = LVL_ZERO;
      end else if (push_s & ~pop_s) begin
         level_s = level_r + LVL_ONE;
      end else if (pop_s & ~push_s) begin
         level_s = level_r - LVL_ONE;
      end else begin
         level_s = level_r;
      end
   end

   // Register read mux
   always_comb begin
      dout = 8'h00;
      case (A)
         ADR_LO:   dout = lo_hold_r;
         ADR_HI:   dout = 8'h00;
         ADR_CTRL: dout = {ovf_r, unf_r, full_s, empty_s, 3'b000, enable_r};
         ADR_LVL:  dout = {{(7 - AW){1'b0}}, level_r};
         default:  dout = 8'h00;
      endcase
   end

   // Sample storage; contents need no reset
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {din, lo_hold_r};
      end
   end

   // Control, pointer, flag and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_r    <= {AW{1'b0}};
         wr_ptr_r    <= {AW{1'b0}};
         level_r     <= LVL_ZERO;
         threshold_r <= THR_RST;
         lo_hold_r   <= 8'h00;
         enable_r    <= 1'b0;
         ovf_r       <= 1'b0;
         unf_r       <= 1'b0;
         lrck_d_r    <= 1'b0;
         sample_out  <= 16'h0000;
         req         <= 1'b1;
      end else begin
         lrck_d_r <= lrck;
         level_r  <= level_s;
         req      <= (level_s <= threshold_r);
         if (wr_lo_s) begin
            lo_hold_r <= din;
         end
         if (wr_lvl_s) begin
            threshold_r <= din[AW:0];
         end
         if (wr_ctrl_s) begin
            enable_r <= din[0];
         end
         if (flush_s) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
         end
         // mute on any rise that does not pop; flush leaves the held sample alone
         if (rise_s & ~flush_s) begin
            sample_out <= pop_s ? mem_r[rd_ptr_r] : 16'h0000;
         end
         if (ovf_set_s) begin
            ovf_r <= 1'b1;
         end else if (clr_s) begin
            ovf_r <= 1'b0;
         end
         if (unf_set_s) begin
            unf_r <= 1'b1;
         end else if (clr_s) begin
            unf_r <= 1'b0;
         end
      end
   end

endmodule
